esc_ramp_ctrl: RTL and testbench
================================

Name: esc_ramp_ctrl

Overview:
Sequencer for the four ESC PWM channels (front, back, left, right) of the quadcopter.
- Runs the arm sequence, then slew-limits commanded motor speeds so each changes by at most MAX_STEP per PWM frame.
- Holds the per-motor OFF calibration registers and drives each ESC interface's SPEED/OFF inputs.
- Handles kill and controlled ramp-down.

Parameters:
FRAME_CYCLES, 1048576, clocks per update frame (matches the 20-bit ESC period).
ARM_FRAMES, 8, frames of zero speed held before RUN.
MAX_STEP, 64, max per-frame speed change per motor (unsigned, 11 bits).
SPD_MAX, 2047, command saturation limit.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
go  input  1  level; high = arm/run, low = ramp down
kill  input  1  level; immediate forced stop
cmd_vld  input  1  one-cycle strobe; latch the four *_cmd inputs
frnt_cmd, bck_cmd, lft_cmd, rght_cmd  input  11 each  requested speeds
cal_wr  input  1  calibration write strobe
cal_sel  input  2  0=frnt 1=bck 2=lft 3=rght
cal_data  input  10  OFF value
frnt_spd, bck_spd, lft_spd, rght_spd  output  11 each  SPEED to ESC interfaces
frnt_off, bck_off, lft_off, rght_off  output  10 each  OFF to ESC interfaces
armed  output  1  high in RUN and RAMPDN
upd_done  output  1  one-cycle pulse after a frame update completes
cal_err  output  1  one-cycle pulse when cal_wr is rejected

Behaviour:
- Reset (async, rst_n low): all *_spd=0, *_off=0, shadow commands=0, state IDLE, frame counter 0, armed=0, upd_done=0, cal_err=0. Reset mid-update abandons the update; no partial state is retained.
- Frame counter: counts 0..FRAME_CYCLES-1 and wraps. frame_tick is high when count==FRAME_CYCLES-1. The counter free-runs in all states.
- cmd_vld: latches the four commands into shadow registers, each saturated to SPD_MAX. Accepted in any state; used only in RUN.
- Snapshot: at frame_tick the shadow registers are copied to targets. If cmd_vld arrives on the same cycle as frame_tick, the snapshot takes the pre-edge shadow value and the new command applies next frame.
- States:
  - IDLE: speeds 0. go and !kill -> ARM; arm frame counter cleared.
  - ARM: speeds 0. Counts frame_ticks. After ARM_FRAMES ticks -> RUN. go low -> IDLE.
  - RUN: on each frame_tick the update engine runs. go low -> RAMPDN.
  - RAMPDN: update engine runs with targets forced to 0. When all four speeds are 0 at the end of an update -> IDLE. go high again -> RUN with no new arm sequence.
  - KILL: entered from any state when kill=1; kill has priority over go. All *_spd are 0 on the cycle after kill is sampled. Exit to IDLE only when kill=0 and go=0.
- Update engine (RUN/RAMPDN):
  - One shared step unit, time-multiplexed. Channel order: frnt, bck, lft, rght.
  - One channel per clock, starting the cycle after frame_tick. Channel k's output updates k+1 cycles after the frame_tick cycle.
  - upd_done pulses on the cycle after rght is written.
  - Step rule, with diff computed signed in 12 bits: if |target-cur| <= MAX_STEP then cur=target; else cur = cur ± MAX_STEP toward target. The result never overshoots and stays within 0..SPD_MAX.
  - The engine does not run in IDLE/ARM/KILL. A kill asserted mid-update aborts the update.
- Calibration:
  - cal_wr in IDLE writes cal_data into the cal_sel OFF register. The value is visible on *_off the next cycle.
  - cal_wr in any other state is ignored and cal_err pulses for one cycle.
  - cal_wr and go on the same IDLE cycle: the write is accepted and the state still goes to ARM.
- *_off outputs are constant outside calibration writes; OFF values are not cleared by kill.

Decomposition:
- Package esc_pkg: state enum (IDLE, ARM, RUN, RAMPDN, KILL); NUM_MOT=4; SPD_W=11; OFF_W=10; channel index type.
- Sub-module esc_slew_step: combinational (cur, target, max_step) -> next, 11 bits. It is instantiated once and shared by the engine.

Test Plan:
(All with FRAME_CYCLES=16, ARM_FRAMES=2, MAX_STEP=64.)
1. Reset/arm: release rst_n, cal_wr sel=2 data=10'h055, then go=1 -> lft_off=0x055 next cycle; all spd=0 until 2 frame_ticks elapse; armed rises on RUN entry.
2. Ramp up: in RUN, cmd_vld with all cmds=200 -> frnt_spd after successive frames: 64, 128, 192, 200; the other channels follow 1, 2 and 3 cycles later than frnt; upd_done pulses once per frame.
3. Small step and saturation: cur=200, cmd=230 -> 230 after one frame. Cmd set to 2047 from 2000 -> 2047 after one frame with no overflow.
4. Ramp down: go=0 with all spd=200 -> RAMPDN; values 136, 72, 8, 0; state reaches IDLE after the frame in which all four are 0; armed falls.
5. Kill: kill=1 mid-update with spd=500 -> all spd=0 next cycle and state KILL. go=1 while kill=1 stays in KILL. kill=0, go=0 -> IDLE.
6. Rejected cal and collision: cal_wr in RUN -> cal_err pulses one cycle and the OFF register is unchanged. cmd_vld=300 on the frame_tick cycle -> that frame uses the old target; 300 is tracked from the next frame.

Source files
------------

// File: rtl/esc_pkg.sv
// ============================================================================
// esc_pkg : shared types and widths for the ESC ramp sequencer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package esc_pkg;

  localparam int NUM_MOT = 4;
  localparam int SPD_W   = 11;
  localparam int OFF_W   = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_RUN    = 3'd2,
    ST_RAMPDN = 3'd3,
    ST_KILL   = 3'd4
  } state_e;

  typedef logic [$clog2(NUM_MOT)-1:0] ch_idx_t;

  function automatic logic [SPD_W-1:0] sat_spd(input logic [SPD_W-1:0] v,
                                               input logic [SPD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/esc_slew_step.sv
// ============================================================================
// esc_slew_step : moves cur toward target by at most max_step, never past it
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module esc_slew_step
  import esc_pkg::*;
(
  input  logic [SPD_W-1:0] cur,
  input  logic [SPD_W-1:0] target,
  input  logic [SPD_W-1:0] max_step,
  output logic [SPD_W-1:0] nxt
);

  logic signed [SPD_W:0] diff;
  logic        [SPD_W:0] mag;

  always_comb begin
    diff = $signed({1'b0, target}) - $signed({1'b0, cur});
    mag  = diff[SPD_W] ? $unsigned(-diff) : $unsigned(diff);
    if (mag <= {1'b0, max_step}) begin
      nxt = target;
    end else if (diff[SPD_W]) begin
      nxt = cur - max_step;
    end else begin
      nxt = cur + max_step;
    end
  end

endmodule

`default_nettype wire

// File: rtl/esc_ramp_ctrl.sv
// ============================================================================
// esc_ramp_ctrl : arm sequencing, per-frame slew limiting, kill and ramp-down
//                 for the four ESC channels, plus OFF calibration registers
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module esc_ramp_ctrl
  import esc_pkg::*;
#(
  parameter int FRAME_CYCLES = 1048576,
  parameter int ARM_FRAMES   = 8,
  parameter int MAX_STEP     = 64,
  parameter int SPD_MAX      = 2047
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        kill,
  input  logic        cmd_vld,
  input  logic [10:0] frnt_cmd,
  input  logic [10:0] bck_cmd,
  input  logic [10:0] lft_cmd,
  input  logic [10:0] rght_cmd,
  input  logic        cal_wr,
  input  logic [1:0]  cal_sel,
  input  logic [9:0]  cal_data,
  output logic [10:0] frnt_spd,
  output logic [10:0] bck_spd,
  output logic [10:0] lft_spd,
  output logic [10:0] rght_spd,
  output logic [9:0]  frnt_off,
  output logic [9:0]  bck_off,
  output logic [9:0]  lft_off,
  output logic [9:0]  rght_off,
  output logic        armed,
  output logic        upd_done,
  output logic        cal_err
);

  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int ARM_W = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_FRAMES - 1);
  localparam logic [SPD_W-1:0] STEP_MAX = SPD_W'(MAX_STEP);
  localparam logic [SPD_W-1:0] SPD_SAT  = SPD_W'(SPD_MAX);
  localparam ch_idx_t          CH_LAST  = ch_idx_t'(NUM_MOT - 1);

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [ARM_W-1:0]                arm_cnt_q, arm_cnt_d;
  logic [NUM_MOT-1:0][SPD_W-1:0]   shadow_q, shadow_d;
  logic [NUM_MOT-1:0][SPD_W-1:0]   target_q, target_d;
  logic [NUM_MOT-1:0][SPD_W-1:0]   spd_q, spd_d;
  logic [NUM_MOT-1:0][OFF_W-1:0]   off_q, off_d;
  logic                            busy_q, busy_d;
  ch_idx_t                         ch_q, ch_d;
  logic                            upd_done_q, upd_done_d;
  logic                            cal_err_q, cal_err_d;

  logic [NUM_MOT-1:0][SPD_W-1:0]   cmd_in;
  logic                            frame_tick;
  logic                            eng_mode;
  logic                            eng_active;
  logic [SPD_W-1:0]                step_cur;
  logic [SPD_W-1:0]                step_tgt;
  logic [SPD_W-1:0]                step_next;

  assign cmd_in     = {rght_cmd, lft_cmd, bck_cmd, frnt_cmd};
  assign frame_tick = (cnt_q == CNT_LAST);
  assign eng_mode   = (state_q == ST_RUN) || (state_q == ST_RAMPDN);
  assign eng_active = busy_q && eng_mode && !kill;

  // Ramp-down reuses the normal engine with a zero target.
  assign step_cur = spd_q[ch_q];
  assign step_tgt = (state_q == ST_RAMPDN) ? '0 : target_q[ch_q];

  esc_slew_step u_step (
    .cur      (step_cur),
    .target   (step_tgt),
    .max_step (STEP_MAX),
    .nxt      (step_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    if (kill) begin
      state_d = ST_KILL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            state_d   = ST_ARM;
            arm_cnt_d = '0;
          end
        end
        ST_ARM: begin
          if (!go) begin
            state_d = ST_IDLE;
          end else if (frame_tick) begin
            if (arm_cnt_q == ARM_LAST) begin
              state_d = ST_RUN;
            end else begin
              arm_cnt_d = arm_cnt_q + ARM_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (!go) begin
            state_d = ST_RAMPDN;
          end
        end
        ST_RAMPDN: begin
          if (go) begin
            state_d = ST_RUN;
          end else if (upd_done_q && (spd_q == '0)) begin
            state_d = ST_IDLE;
          end
        end
        ST_KILL: begin
          if (!go) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    armed = (state_q == ST_RUN) || (state_q == ST_RAMPDN);
  end

  always_comb begin
    cnt_d      = frame_tick ? '0 : cnt_q + CNT_W'(1);
    shadow_d   = shadow_q;
    target_d   = frame_tick ? shadow_q : target_q;
    spd_d      = spd_q;
    busy_d     = busy_q;
    ch_d       = ch_q;
    upd_done_d = 1'b0;
    off_d      = off_q;
    cal_err_d  = 1'b0;

    if (cmd_vld) begin
      for (int m = 0; m < NUM_MOT; m++) begin
        shadow_d[m] = sat_spd(cmd_in[m], SPD_SAT);
      end
    end

    if (eng_active) begin
      spd_d[ch_q] = step_next;
      if (ch_q == CH_LAST) begin
        busy_d     = 1'b0;
        ch_d       = '0;
        upd_done_d = 1'b1;
      end else begin
        ch_d = ch_q + ch_idx_t'(1);
      end
    end

    if (frame_tick && eng_mode) begin
      busy_d = 1'b1;
      ch_d   = '0;
    end

    // Kill and the non-running states abandon any update in flight.
    if (kill || !eng_mode) begin
      busy_d     = 1'b0;
      ch_d       = '0;
      spd_d      = '0;
      upd_done_d = 1'b0;
    end

    if (cal_wr) begin
      if (state_q == ST_IDLE) begin
        off_d[cal_sel] = cal_data;
      end else begin
        cal_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      arm_cnt_q  <= '0;
      shadow_q   <= '0;
      target_q   <= '0;
      spd_q      <= '0;
      off_q      <= '0;
      busy_q     <= 1'b0;
      ch_q       <= '0;
      upd_done_q <= 1'b0;
      cal_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      arm_cnt_q  <= arm_cnt_d;
      shadow_q   <= shadow_d;
      target_q   <= target_d;
      spd_q      <= spd_d;
      off_q      <= off_d;
      busy_q     <= busy_d;
      ch_q       <= ch_d;
      upd_done_q <= upd_done_d;
      cal_err_q  <= cal_err_d;
    end
  end

  assign frnt_spd = spd_q[0];
  assign bck_spd  = spd_q[1];
  assign lft_spd  = spd_q[2];
  assign rght_spd = spd_q[3];
  assign frnt_off = off_q[0];
  assign bck_off  = off_q[1];
  assign lft_off  = off_q[2];
  assign rght_off = off_q[3];
  assign upd_done = upd_done_q;
  assign cal_err  = cal_err_q;

endmodule

`default_nettype wire

// File: tb/tb_esc_ramp_ctrl.sv
// ============================================================================
// tb_esc_ramp_ctrl : directed bench for esc_ramp_ctrl (16-cycle frames,
//                    2 arm frames, step 64)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_esc_ramp_ctrl;

  typedef struct {
    logic             vld;
    logic [3:0][10:0] cmd;
    logic [3:0][10:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        kill = 1'b0;
  logic        cmd_vld = 1'b0;
  logic [10:0] frnt_cmd = '0, bck_cmd = '0, lft_cmd = '0, rght_cmd = '0;
  logic        cal_wr = 1'b0;
  logic [1:0]  cal_sel = '0;
  logic [9:0]  cal_data = '0;
  logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  logic [9:0]  frnt_off, bck_off, lft_off, rght_off;
  logic        armed, upd_done, cal_err;

  logic [3:0][10:0] spd_all;
  assign spd_all = {rght_spd, lft_spd, bck_spd, frnt_spd};

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  vec_t tbl [9];

  esc_ramp_ctrl #(
    .FRAME_CYCLES (16),
    .ARM_FRAMES   (2),
    .MAX_STEP     (64),
    .SPD_MAX      (2047)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .kill     (kill),
    .cmd_vld  (cmd_vld),
    .frnt_cmd (frnt_cmd),
    .bck_cmd  (bck_cmd),
    .lft_cmd  (lft_cmd),
    .rght_cmd (rght_cmd),
    .cal_wr   (cal_wr),
    .cal_sel  (cal_sel),
    .cal_data (cal_data),
    .frnt_spd (frnt_spd),
    .bck_spd  (bck_spd),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .frnt_off (frnt_off),
    .bck_off  (bck_off),
    .lft_off  (lft_off),
    .rght_off (rght_off),
    .armed    (armed),
    .upd_done (upd_done),
    .cal_err  (cal_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(input logic [10:0] f, input logic [10:0] b,
                      input logic [10:0] l, input logic [10:0] r);
    frnt_cmd = f; bck_cmd = b; lft_cmd = l; rght_cmd = r;
    cmd_vld  = 1'b1;
    step();
    cmd_vld  = 1'b0;
  endtask

  task automatic wait_upd();
    int n = 0;
    do begin
      step();
      n++;
    end while (!upd_done && n < 40);
    if (!upd_done) chk("upd_done_timeout", 0, 1);
  endtask

  task automatic ramp_to(input logic [10:0] v);
    logic done = 1'b0;
    send(v, v, v, v);
    for (int k = 0; k < 40 && !done; k++) begin
      wait_upd();
      done = (spd_all == {v, v, v, v});
    end
    chk("ramp_to", done, 1);
  endtask

  function automatic vec_t mk(input logic vld,
                              input int c0, input int c1, input int c2, input int c3,
                              input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.vld = vld;
    v.cmd[0] = 11'(c0); v.cmd[1] = 11'(c1); v.cmd[2] = 11'(c2); v.cmd[3] = 11'(c3);
    v.exp[0] = 11'(e0); v.exp[1] = 11'(e1); v.exp[2] = 11'(e2); v.exp[3] = 11'(e3);
    return v;
  endfunction

  initial begin
    int bad;
    int seen;

    // Successive frames after the first 200-command frame (all at 64).
    tbl[0] = mk(1'b0,   0,   0,   0,    0,  128, 128, 128, 128);
    tbl[1] = mk(1'b0,   0,   0,   0,    0,  192, 192, 192, 192);
    tbl[2] = mk(1'b0,   0,   0,   0,    0,  200, 200, 200, 200);
    tbl[3] = mk(1'b1, 230, 200, 100,    0,  230, 200, 136, 136);
    tbl[4] = mk(1'b0,   0,   0,   0,    0,  230, 200, 100,  72);
    tbl[5] = mk(1'b1,  72,  72,  72,   72,  166, 136,  72,  72);
    tbl[6] = mk(1'b0,   0,   0,   0,    0,  102,  72,  72,  72);
    tbl[7] = mk(1'b1,   0, 137,   8, 2047,   38, 136,   8, 136);
    tbl[8] = mk(1'b0,   0,   0,   0,    0,    0, 137,   8, 200);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    chk("rst_spd", spd_all, 0);
    chk("rst_off", {frnt_off, bck_off, lft_off, rght_off}, 0);
    chk("rst_armed", armed, 0);
    chk("rst_upd_done", upd_done, 0);
    chk("rst_cal_err", cal_err, 0);

    cal_wr = 1'b1; cal_sel = 2'd2; cal_data = 10'h055;
    step();
    chk("cal_lft_off", lft_off, 10'h055);
    cal_sel = 2'd1; cal_data = 10'h2C3; go = 1'b1;
    step();
    chk("cal_go_bck_off", bck_off, 10'h2C3);
    chk("cal_go_err", cal_err, 0);
    cal_wr = 1'b0;

    bad = 0;
    while (cyc < 31) begin
      step();
      if (armed || spd_all != 0) bad++;
    end
    chk("arm_hold", bad, 0);
    step();
    chk("armed_rise", armed, 1);

    // First ramp frame: tick at cycle 47, frnt visible at 49, rght and upd_done at 52.
    send(200, 200, 200, 200);
    while (cyc < 48) step();
    chk("frnt_before", frnt_spd, 0);
    step();
    chk("frnt_64", frnt_spd, 64);
    chk("bck_lag", bck_spd, 0);
    step();
    chk("bck_64", bck_spd, 64);
    chk("lft_lag", lft_spd, 0);
    step();
    chk("lft_64", lft_spd, 64);
    chk("rght_lag", rght_spd, 0);
    step();
    chk("rght_64", rght_spd, 64);
    chk("upd_done_pulse", upd_done, 1);
    step();
    chk("upd_done_clear", upd_done, 0);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].vld) send(tbl[i].cmd[0], tbl[i].cmd[1], tbl[i].cmd[2], tbl[i].cmd[3]);
      wait_upd();
      chk($sformatf("vec%0d_frnt", i), frnt_spd, tbl[i].exp[0]);
      chk($sformatf("vec%0d_bck", i),  bck_spd,  tbl[i].exp[1]);
      chk($sformatf("vec%0d_lft", i),  lft_spd,  tbl[i].exp[2]);
      chk($sformatf("vec%0d_rght", i), rght_spd, tbl[i].exp[3]);
    end

    cal_wr = 1'b1; cal_sel = 2'd2; cal_data = 10'h1FF;
    step();
    cal_wr = 1'b0;
    chk("run_cal_err", cal_err, 1);
    chk("run_cal_keep", lft_off, 10'h055);
    step();
    chk("run_cal_err_clear", cal_err, 0);

    // Collision: upd_done is 5 cycles after a tick, so the next tick is 11 later.
    ramp_to(200);
    repeat (11) step();
    send(300, 300, 300, 300);
    wait_upd();
    chk("collide_old", spd_all, {11'd200, 11'd200, 11'd200, 11'd200});
    wait_upd();
    chk("collide_264", spd_all, {11'd264, 11'd264, 11'd264, 11'd264});
    wait_upd();
    chk("collide_300", spd_all, {11'd300, 11'd300, 11'd300, 11'd300});

    ramp_to(2000);
    send(2047, 1900, 2047, 0);
    wait_upd();
    chk("sat_top", spd_all, {11'd1936, 11'd2047, 11'd1936, 11'd2047});

    ramp_to(200);
    go = 1'b0;
    wait_upd();
    chk("rdn_136", spd_all, {11'd136, 11'd136, 11'd136, 11'd136});
    chk("rdn_armed", armed, 1);
    wait_upd();
    chk("rdn_72", spd_all, {11'd72, 11'd72, 11'd72, 11'd72});
    wait_upd();
    chk("rdn_8", spd_all, {11'd8, 11'd8, 11'd8, 11'd8});
    wait_upd();
    chk("rdn_0", spd_all, 0);
    step();
    chk("rdn_idle_armed", armed, 0);

    go = 1'b1;
    for (int k = 0; k < 60 && !armed; k++) step();
    chk("rearm", armed, 1);
    ramp_to(500);

    // Kill lands after frnt is written but before bck.
    repeat (13) step();
    kill = 1'b1;
    step();
    chk("kill_spd", spd_all, 0);
    chk("kill_armed", armed, 0);
    seen = 0;
    repeat (5) begin
      step();
      if (upd_done) seen++;
    end
    chk("kill_abort", seen, 0);
    repeat (40) step();
    chk("kill_go_hold_armed", armed, 0);
    chk("kill_go_hold_spd", spd_all, 0);

    kill = 1'b0;
    step();
    cal_wr = 1'b1; cal_sel = 2'd3; cal_data = 10'h123;
    step();
    chk("kill_stay_cal_err", cal_err, 1);
    chk("kill_stay_off", rght_off, 0);
    cal_wr = 1'b0; go = 1'b0;
    step();
    cal_wr = 1'b1; cal_sel = 2'd0; cal_data = 10'h3AA;
    step();
    cal_wr = 1'b0;
    chk("idle_cal_err", cal_err, 0);
    chk("idle_frnt_off", frnt_off, 10'h3AA);
    chk("off_kept_lft", lft_off, 10'h055);
    chk("off_kept_bck", bck_off, 10'h2C3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
